// File: rtl/pixel_write_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_write_sink                                                           |
// | Stages the drawing controller's pixel stream, drops off-screen pixels and  |
// | buffers framebuffer writes in a show-ahead FIFO to absorb port stalls.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pixel_write_sink #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    plot,
  input  logic [8:0]              xPos,
  input  logic [7:0]              yPos,
  input  logic [2:0]              colorIn,
  output logic                    wrEn,
  output logic [16:0]             wrAddr,
  output logic [2:0]              wrData,
  input  logic                    wrReady,
  input  logic                    clearOverflow,
  output logic                    overflow,
  output logic [7:0]              dropCount,
  output logic [$clog2(DEPTH):0]  fifoCount,
  output logic                    idle
);

  localparam int              c_ptrW   = $clog2(DEPTH);
  localparam int              c_cntW   = c_ptrW + 1;
  localparam int              c_entryW = 20;
  localparam logic [16:0]     c_width  = 17'(WIDTH);
  localparam logic [16:0]     c_height = 17'(HEIGHT);
  localparam logic [c_cntW-1:0] c_depth = c_cntW'(DEPTH);

  // Input stage
  logic        r_stageValid;
  logic [8:0]  r_x;
  logic [7:0]  r_y;
  logic [2:0]  r_color;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_stageValid <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_color      <= '0;
    end else begin
      r_stageValid <= plot;
      r_x          <= xPos;
      r_y          <= yPos;
      r_color      <= colorIn;
    end
  end

  logic [16:0] w_addr;
  logic        w_inRange;

  assign w_inRange = (17'(r_x) < c_width) && (17'(r_y) < c_height);

  generate
    if (WIDTH == 320) begin : g_shiftAdd
      assign w_addr = (17'(r_y) << 8) + (17'(r_y) << 6) + 17'(r_x);
    end else begin : g_mult
      assign w_addr = 17'(r_y) * c_width + 17'(r_x);
    end
  endgenerate

  // FIFO control
  logic [c_ptrW-1:0]   r_wrPtr;
  logic [c_ptrW-1:0]   r_rdPtr;
  logic [c_cntW-1:0]   r_count;
  logic [c_entryW-1:0] r_mem [DEPTH];
  logic [c_entryW-1:0] w_head;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_lost;
  logic                w_drop;

  assign w_full = (r_count == c_depth);
  assign w_pop  = wrEn && wrReady;
  // A full FIFO still accepts a pixel when the head leaves on the same edge.
  assign w_push = r_stageValid && w_inRange && (!w_full || w_pop);
  assign w_lost = r_stageValid && w_inRange && w_full && !w_pop;
  assign w_drop = r_stageValid && !w_inRange;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {w_addr, r_color};
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Statistics: a new event in the same cycle as a clear takes precedence.
  logic       r_overflow;
  logic [7:0] r_dropCount;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end else begin
      if (w_lost) begin
        r_overflow <= 1'b1;
      end else if (clearOverflow) begin
        r_overflow <= 1'b0;
      end
      if (clearOverflow) begin
        r_dropCount <= w_drop ? 8'd1 : 8'd0;
      end else if (w_drop && (r_dropCount != 8'hFF)) begin
        r_dropCount <= r_dropCount + 8'd1;
      end
    end
  end

  // Head entry is presented directly; outputs read as zero while empty.
  assign w_head    = r_mem[r_rdPtr];
  assign wrEn      = (r_count != '0);
  assign wrAddr    = wrEn ? w_head[c_entryW-1:3] : 17'd0;
  assign wrData    = wrEn ? w_head[2:0] : 3'd0;
  assign overflow  = r_overflow;
  assign dropCount = r_dropCount;
  assign fifoCount = r_count;
  assign idle      = !r_stageValid && (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_pixel_write_sink.sv
`default_nettype none
// Directed bench for pixel_write_sink: a scoreboard queue of expected writes
// is filled as pixels are plotted and drained by a negedge write monitor.
module tb_pixel_write_sink;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        plot = 1'b0;
  logic [8:0]  xPos = '0;
  logic [7:0]  yPos = '0;
  logic [2:0]  colorIn = '0;
  logic        wrEn;
  logic [16:0] wrAddr;
  logic [2:0]  wrData;
  logic        wrReady = 1'b1;
  logic        clearOverflow = 1'b0;
  logic        overflow;
  logic [7:0]  dropCount;
  logic [4:0]  fifoCount;
  logic        idle;

  int total = 0;
  int bad = 0;
  int writeCnt = 0;
  logic [19:0] sbQ[$];

  logic        stallPrev = 1'b0;
  logic [16:0] prevAddr = '0;
  logic [2:0]  prevData = '0;

  pixel_write_sink #(.DEPTH(16), .WIDTH(320), .HEIGHT(240)) dut (
    .clk(clk), .Reset(Reset), .plot(plot), .xPos(xPos), .yPos(yPos),
    .colorIn(colorIn), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .wrReady(wrReady), .clearOverflow(clearOverflow), .overflow(overflow),
    .dropCount(dropCount), .fifoCount(fifoCount), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one plot cycle; expected writes enter the scoreboard in plot order.
  task automatic plotPx(input int x, input int y, input int c, input bit expectWrite);
    plot = 1'b1;
    xPos = 9'(x);
    yPos = 8'(y);
    colorIn = 3'(c);
    if (expectWrite) sbQ.push_back({17'(y * 320 + x), 3'(c)});
    tick();
    plot = 1'b0;
  endtask

  always @(negedge clk) begin
    if (Reset) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        check("hold_wren", 32'(wrEn), 1);
        check("hold_addr", 32'(wrAddr), 32'(prevAddr));
        check("hold_data", 32'(wrData), 32'(prevData));
      end
      if (wrEn && wrReady) begin
        logic [19:0] exp;
        writeCnt++;
        total++;
        assert (sbQ.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_write: observed addr=%0d expected no write", wrAddr);
        end
        if (sbQ.size() != 0) begin
          exp = sbQ.pop_front();
          check("wr_addr", 32'(wrAddr), 32'(exp[19:3]));
          check("wr_data", 32'(wrData), 32'(exp[2:0]));
        end
      end
      stallPrev = wrEn && !wrReady;
      prevAddr = wrAddr;
      prevData = wrData;
    end
  end

  initial begin
    int w0;
    tick(3);
    Reset = 1'b0;
    tick();

    // Reset state
    check("rst_wren", 32'(wrEn), 0);
    check("rst_fifocount", 32'(fifoCount), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_dropcount", 32'(dropCount), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_wraddr", 32'(wrAddr), 0);
    check("rst_wrdata", 32'(wrData), 0);

    // Single pixel latency
    plotPx(5, 3, 6, 1);
    check("single_stage_wren", 32'(wrEn), 0);
    check("single_stage_idle", 32'(idle), 0);
    tick();
    check("single_wren", 32'(wrEn), 1);
    check("single_addr", 32'(wrAddr), 965);
    check("single_data", 32'(wrData), 6);
    tick();
    check("single_wren_off", 32'(wrEn), 0);
    check("single_idle", 32'(idle), 1);
    check("single_sb_empty", 32'(sbQ.size()), 0);

    // Bounds
    plotPx(319, 239, 5, 1);
    plotPx(320, 0, 1, 0);
    plotPx(0, 240, 2, 0);
    tick(3);
    check("bounds_dropcount", 32'(dropCount), 2);
    check("bounds_overflow", 32'(overflow), 0);
    check("bounds_sb_empty", 32'(sbQ.size()), 0);

    // Clear coinciding with a drop leaves dropCount at 1
    plotPx(400, 0, 0, 0);
    clearOverflow = 1'b1;
    tick();
    clearOverflow = 1'b0;
    check("clear_with_drop", 32'(dropCount), 1);

    // Saturation
    for (int i = 0; i < 260; i++) plotPx(400 + (i % 100), 0, 0, 0);
    tick();
    check("drop_saturate", 32'(dropCount), 255);
    clearOverflow = 1'b1;
    tick();
    clearOverflow = 1'b0;
    check("drop_clear", 32'(dropCount), 0);

    // Backpressure
    wrReady = 1'b0;
    for (int i = 0; i < 16; i++) plotPx(i, 0, i, 1);
    tick(3);
    check("bp_fifocount", 32'(fifoCount), 16);
    check("bp_overflow", 32'(overflow), 0);
    check("bp_addr_held", 32'(wrAddr), 0);
    check("bp_idle", 32'(idle), 0);
    w0 = writeCnt;
    wrReady = 1'b1;
    tick(16);
    check("bp_drain_writes", writeCnt - w0, 16);
    check("bp_drain_empty", 32'(fifoCount), 0);
    check("bp_sb_empty", 32'(sbQ.size()), 0);

    // Overflow
    wrReady = 1'b0;
    for (int i = 0; i < 18; i++) plotPx(i, 1, i + 3, i < 16);
    tick();
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_fifocount", 32'(fifoCount), 16);
    check("ovf_no_drop", 32'(dropCount), 0);
    clearOverflow = 1'b1;
    tick();
    clearOverflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);
    wrReady = 1'b1;
    tick(16);
    check("ovf_drain_empty", 32'(fifoCount), 0);
    check("ovf_sb_empty", 32'(sbQ.size()), 0);

    // Full with simultaneous pop
    wrReady = 1'b0;
    for (int i = 0; i < 16; i++) plotPx(i + 20, 2, i, 1);
    tick();
    check("fullpop_pre", 32'(fifoCount), 16);
    plotPx(100, 2, 7, 1);
    wrReady = 1'b1;
    tick();
    check("fullpop_count", 32'(fifoCount), 16);
    check("fullpop_overflow", 32'(overflow), 0);
    tick(16);
    check("fullpop_drain", 32'(fifoCount), 0);
    check("fullpop_sb_empty", 32'(sbQ.size()), 0);

    // Reset mid-burst
    wrReady = 1'b0;
    for (int i = 0; i < 9; i++) plotPx(i, 4, i, 1);
    tick();
    check("midrst_pre", 32'(fifoCount), 9);
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_wren", 32'(wrEn), 0);
    check("midrst_fifocount", 32'(fifoCount), 0);
    check("midrst_idle", 32'(idle), 1);
    sbQ.delete();
    tick();
    Reset = 1'b0;
    w0 = writeCnt;
    wrReady = 1'b1;
    tick(5);
    check("midrst_no_stale", writeCnt - w0, 0);
    check("midrst_wren_after", 32'(wrEn), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
